// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer for a dual-issue front end. It owns the fetch PC,
// issues one 64-bit instruction-pair request at a time to instruction memory
// and holds the returned pair in a one-entry register for decode. A taken
// redirect from either decode slot retargets the PC and squashes any
// wrong-path request that is already in flight.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 64
) (
    input  logic              clk,
    input  logic              reset,

    // Decode-side control and redirect sources
    input  logic              stall_d,
    input  logic              valid_d,
    input  logic [1:0]        pcsrc_d_0,
    input  logic [1:0]        pcsrc_d_1,
    input  logic [31:0]       pc_predict_d_0,
    input  logic [31:0]       pc_predict_d_1,
    input  logic [31:0]       pc_jump_d_0,
    input  logic [31:0]       pc_jump_d_1,

    // Instruction memory request/response
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [31:0]       imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,

    // Held pair presented to decode
    output logic              fetch_valid_f,
    output logic [31:0]       pc_f_0,
    output logic [31:0]       pc_f_1,
    output logic [31:0]       pc_plus_8_f,
    output logic [31:0]       instr_f_0,
    output logic [31:0]       instr_f_1
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // presenting a request, waiting for ready
        S_WAIT = 2'd1,  // one request outstanding, waiting for its response
        S_HOLD = 2'd2   // pair held for decode, waiting to be consumed
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic        drop_q;        // outstanding response belongs to a squashed path
    logic        fetch_valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr0_q;
    logic [31:0] instr1_q;

    logic        sel0;
    logic        sel1;
    logic        take_redirect;
    logic        consume;
    logic [31:0] redirect_pc;

    // Code 3 is deliberately not a redirect: only predict (1) and jump (2) count.
    assign sel0          = (pcsrc_d_0 == 2'd1) || (pcsrc_d_0 == 2'd2);
    assign sel1          = (pcsrc_d_1 == 2'd1) || (pcsrc_d_1 == 2'd2);
    assign take_redirect = valid_d && !stall_d && (sel0 || sel1);
    assign consume       = fetch_valid_q && !stall_d;

    // Redirect target: slot 0 wins; slot 1 only when slot 0 is sequential.
    always_comb begin
        // NOTE: assign a default before the branches so no path leaves
        // redirect_pc unassigned, which would infer a latch.
        redirect_pc = pc_jump_d_1;
        if (sel0) begin
            redirect_pc = (pcsrc_d_0 == 2'd1) ? pc_predict_d_0 : pc_jump_d_0;
        end else if (pcsrc_d_1 == 2'd1) begin
            redirect_pc = pc_predict_d_1;
        end
    end

    // Fetch FSM, PC, squash flag and decode output register in one process.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC;
            drop_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
            pc_q          <= 32'h0;
            instr0_q      <= 32'h0;
            instr1_q      <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge value of the registers regardless of statement order.
            unique case (state_q)
                S_REQ: begin
                    if (take_redirect) begin
                        fetch_pc_q    <= redirect_pc;
                        fetch_valid_q <= 1'b0;
                        if (imem_req_ready) begin
                            // The request accepted this cycle is wrong-path.
                            state_q <= S_WAIT;
                            drop_q  <= 1'b1;
                        end
                    end else if (imem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (take_redirect) begin
                        fetch_pc_q    <= redirect_pc;
                        fetch_valid_q <= 1'b0;
                        if (imem_resp_valid) begin
                            // Response lands on the redirect edge: discard it now.
                            state_q <= S_REQ;
                            drop_q  <= 1'b0;
                        end else begin
                            drop_q  <= 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            pc_q          <= fetch_pc_q;
                            instr0_q      <= imem_resp_data[31:0];
                            instr1_q      <= imem_resp_data[63:32];
                            fetch_valid_q <= 1'b1;
                            state_q       <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (take_redirect) begin
                        fetch_pc_q    <= redirect_pc;
                        fetch_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                    end else if (consume) begin
                        fetch_pc_q    <= fetch_pc_q + 32'd8;
                        fetch_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                    end
                end

                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = fetch_pc_q;

    assign fetch_valid_f  = fetch_valid_q;
    assign pc_f_0         = pc_q;
    assign pc_f_1         = pc_q + 32'd4;
    assign pc_plus_8_f    = pc_q + 32'd8;
    assign instr_f_0      = instr0_q;
    assign instr_f_1      = instr1_q;

endmodule
